// File: rtl/riscv_test_monitor.sv
// End-of-test monitor: tohost pass/fail mailbox, hang and timeout detection.
// Optional PC history buffer enabled by RISCV_TEST_MONITOR_PC_HISTORY_EN.
module riscv_test_monitor #(
    parameter int               XLEN           = 32,
    parameter int               CNT_W          = 32,
    parameter logic [XLEN-1:0]  TOHOST_ADDR    = 32'h0000_0FFC,
    parameter int               TIMEOUT_CYCLES = 100,
    parameter int               STALL_LIMIT    = 16,
    parameter int               HIST_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [XLEN-1:0]               pc,
    input  logic                          mem_we,
    input  logic [XLEN-1:0]               mem_addr,
    input  logic [XLEN-1:0]               mem_wdata,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    status,
    output logic [XLEN-2:0]               fail_code,
    output logic [CNT_W-1:0]              cycle_count,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_pc
);

    localparam int SC_W = $clog2(STALL_LIMIT + 1);
    localparam int HW   = $clog2(HIST_DEPTH);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_PASS    = 3'd1,
        S_FAIL    = 3'd2,
        S_TIMEOUT = 3'd3,
        S_HANG    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [XLEN-1:0]   prev_q, prev_d;
    logic [XLEN-2:0]   fc_q, fc_d;
    logic              tohost;
    logic              same_pc;

    assign tohost  = mem_we && (mem_addr == TOHOST_ADDR);
    assign same_pc = (pc == prev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            sc_q    <= '0;
            prev_q  <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            prev_q  <= prev_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        prev_d  = prev_q;
        fc_d    = fc_q;
        if (state_q == S_RUN) begin
            prev_d = pc;
            if (same_pc)
                sc_d = (sc_q == SC_W'(STALL_LIMIT)) ? sc_q : sc_q + 1'b1;
            else
                sc_d = '0;
            if (tohost && mem_wdata == XLEN'(1)) begin
                state_d = S_PASS;
            end else if (tohost && mem_wdata[0]) begin
                state_d = S_FAIL;
                fc_d    = mem_wdata[XLEN-1:1];
            end else if (same_pc && sc_q == SC_W'(STALL_LIMIT - 1)) begin
                state_d = S_HANG;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_TIMEOUT;
            end
            // the verdict edge freezes the count rather than bumping it
            if (state_d == S_RUN && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign status      = state_q;
    assign done        = (state_q != S_RUN);
    assign pass        = (state_q == S_PASS);
    assign fail_code   = fc_q;
    assign cycle_count = cnt_q;

`ifdef RISCV_TEST_MONITOR_PC_HISTORY_EN
    logic [XLEN-1:0] hist_mem [HIST_DEPTH];
    logic [HW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HIST_DEPTH; i++)
                hist_mem[i] <= '0;
            wr_ptr <= '0;
        end else if (state_q == S_RUN) begin
            hist_mem[wr_ptr] <= pc;
            wr_ptr           <= wr_ptr + 1'b1;
        end
    end

    // newest entry sits one slot behind the write pointer
    assign hist_pc = hist_mem[wr_ptr - HW'(1) - hist_idx];
`else
    logic hist_idx_unused;
    assign hist_idx_unused = ^hist_idx;
    assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed self-checking bench for riscv_test_monitor.
// Covers pass, fail, ignored writes, hang, timeout, priorities and reset.
module tb_riscv_test_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        pass;
    logic [2:0]  status;
    logic [30:0] fail_code;
    logic [31:0] cycle_count;
    logic [2:0]  hist_idx;
    logic [31:0] hist_pc;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_test_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .done        (done),
        .pass        (pass),
        .status      (status),
        .fail_code   (fail_code),
        .cycle_count (cycle_count),
        .hist_idx    (hist_idx),
        .hist_pc     (hist_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pc     = '0;
        mem_we = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_changing(input int n);
        for (int i = 0; i < n; i++) begin
            pc = 32'h100 + 32'(i * 4);
            step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        pc        = '0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0000_0FFC;
        mem_wdata = '0;
        hist_idx  = '0;

        // reset state
        do_reset();
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_status", status, 0);
        check("rst_count", cycle_count, 0);
        check("rst_fcode", fail_code, 0);

        // pass: 21 run cycles, then tohost=1
        for (int i = 0; i < 21; i++) begin
            pc = 32'(i * 4);
            step();
        end
        check("pre_pass_status", status, 0);
        check("pre_pass_count", cycle_count, 21);
        pc        = 32'd84;
        mem_we    = 1'b1;
        mem_wdata = 32'd1;
        step();
        mem_we = 1'b0;
        check("pass_done", done, 1);
        check("pass_pass", pass, 1);
        check("pass_status", status, 1);
        check("pass_count", cycle_count, 21);
        pc = 32'd88;
        step();
        check("pass_count_frozen", cycle_count, 21);

        // fail with code 3, later pass write ignored
        do_reset();
        run_changing(5);
        mem_we    = 1'b1;
        mem_wdata = 32'h0000_0007;
        step();
        check("fail_status", status, 2);
        check("fail_pass", pass, 0);
        check("fail_done", done, 1);
        check("fail_code", fail_code, 3);
        check("fail_count", cycle_count, 5);
        mem_wdata = 32'd1;
        step();
        mem_we = 1'b0;
        check("fail_sticky", status, 2);
        check("fail_code_hold", fail_code, 3);

        // even write is ignored; wrong address ignored
        do_reset();
        run_changing(3);
        mem_we    = 1'b1;
        mem_wdata = 32'd2;
        step();
        check("even_ignored", status, 0);
        mem_addr  = 32'h0000_0FF8;
        mem_wdata = 32'd1;
        step();
        mem_we   = 1'b0;
        mem_addr = 32'h0000_0FFC;
        check("addr_ignored", status, 0);
        check("ignored_count", cycle_count, 5);

        // hang: pc held at 0x40
        do_reset();
        pc = 32'h40;
        for (int i = 0; i < 16; i++) step();
        check("pre_hang_status", status, 0);
        step();
        check("hang_status", status, 4);
        check("hang_count", cycle_count, 16);
        step();
        check("hang_count_frozen", cycle_count, 16);

        // reset from HANG
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_hang_done", done, 0);
        check("rst_hang_status", status, 0);
        check("rst_hang_count", cycle_count, 0);

        // reset beats a simultaneous tohost write
        rst       = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = 32'd1;
        step();
        rst    = 1'b0;
        mem_we = 1'b0;
        check("rst_vs_tohost_status", status, 0);
        check("rst_vs_tohost_pass", pass, 0);

        // tohost beats hang on the same edge
        do_reset();
        pc = 32'h40;
        for (int i = 0; i < 16; i++) step();
        mem_we    = 1'b1;
        mem_wdata = 32'h0000_000B;
        step();
        mem_we = 1'b0;
        check("tohost_over_hang", status, 2);
        check("tohost_over_hang_fc", fail_code, 5);

        // timeout
        do_reset();
        run_changing(99);
        check("pre_timeout_status", status, 0);
        check("pre_timeout_count", cycle_count, 99);
        pc = 32'h2000;
        step();
        check("timeout_status", status, 3);
        check("timeout_count", cycle_count, 99);

        // tohost pass beats timeout
        do_reset();
        run_changing(99);
        pc        = 32'h2000;
        mem_we    = 1'b1;
        mem_wdata = 32'd1;
        step();
        mem_we = 1'b0;
        check("pass_over_timeout", status, 1);
        check("pass_over_timeout_cnt", cycle_count, 99);

        // PC history
        do_reset();
`ifdef RISCV_TEST_MONITOR_PC_HISTORY_EN
        hist_idx = 3'd0;
        #1;
        check("hist_empty", hist_pc, 0);
        for (int i = 0; i < 12; i++) begin
            pc = 32'(i * 4);
            step();
        end
        hist_idx = 3'd0;
        #1;
        check("hist_idx0", hist_pc, 44);
        hist_idx = 3'd7;
        #1;
        check("hist_idx7", hist_pc, 16);
        hist_idx = 3'd2;
        #1;
        check("hist_idx2", hist_pc, 36);
`else
        for (int i = 0; i < 12; i++) begin
            pc = 32'(i * 4);
            step();
        end
        hist_idx = 3'd0;
        #1;
        check("hist_off0", hist_pc, 0);
        hist_idx = 3'd5;
        #1;
        check("hist_off5", hist_pc, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
